// File: rtl/alu1_pkg.sv
// Shared types, constants and flag derivation for the Alu1 result stage.
package alu1_pkg;

    localparam int ALU1_CMD_WIDTH = 2;
    localparam logic [ALU1_CMD_WIDTH-1:0] CMD_ADD = 2'd0;
    localparam logic [ALU1_CMD_WIDTH-1:0] CMD_SUB = 2'd1;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef logic [3:0] alu1_flags_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    // Overflow is judged on operand/result sign bits; SUB sees the un-inverted b operand.
    function automatic alu1_flags_t calc_flags(
        input logic [ALU1_CMD_WIDTH-1:0] cmd,
        input logic                      a_msb,
        input logic                      b_msb,
        input logic                      res_msb,
        input logic                      res_zero,
        input logic                      co
    );
        alu1_flags_t f;
        f = 4'b0000;
        case (cmd)
            CMD_ADD: begin
                f[FLAG_V] = (a_msb == b_msb) & (res_msb != a_msb);
                f[FLAG_N] = res_msb;
                f[FLAG_C] = co;
                f[FLAG_Z] = res_zero;
            end
            CMD_SUB: begin
                f[FLAG_V] = (a_msb != b_msb) & (res_msb != a_msb);
                f[FLAG_N] = res_msb;
                f[FLAG_C] = co;
                f[FLAG_Z] = res_zero;
            end
            default: f = 4'b0000;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/alu1_result_stage_skid.sv
// Two-entry skid buffer: output register plus one skid register, with a registered in_ready.
module skid_buf2
    import alu1_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] din,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] dout
);

    occ_t          state_r;
    occ_t          state_nxt_s;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [DW-1:0] dout_r;
    logic [DW-1:0] skid_r;
    logic          push_s;
    logic          pop_s;
    logic          load_out_s;
    logic          load_skid_s;
    logic          skid_to_out_s;

    assign push_s = in_valid & in_ready_r;
    assign pop_s  = out_valid_r & out_ready;

    // Occupancy next-state and storage load selects.
    always_comb begin
        state_nxt_s   = state_r;
        load_out_s    = 1'b0;
        load_skid_s   = 1'b0;
        skid_to_out_s = 1'b0;
        case (state_r)
            EMPTY: begin
                if (push_s) begin
                    state_nxt_s = ONE;
                    load_out_s  = 1'b1;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            ONE: begin
                if (push_s && !pop_s) begin
                    state_nxt_s = TWO;
                    load_skid_s = 1'b1;
                end else if (pop_s && !push_s) begin
                    state_nxt_s = EMPTY;
                end else if (push_s && pop_s) begin
                    state_nxt_s = ONE;
                    load_out_s  = 1'b1;
                end else begin
                    state_nxt_s = ONE;
                end
            end
            TWO: begin
                if (pop_s) begin
                    state_nxt_s   = ONE;
                    skid_to_out_s = 1'b1;
                end else begin
                    state_nxt_s = TWO;
                end
            end
            default: state_nxt_s = EMPTY;
        endcase
    end

    // State, handshake flags and data registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            dout_r      <= '0;
            skid_r      <= '0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s != TWO);
            out_valid_r <= (state_nxt_s != EMPTY);
            if (load_out_s) begin
                dout_r <= din;
            end else if (skid_to_out_s) begin
                dout_r <= skid_r;
            end
            if (load_skid_s) begin
                skid_r <= din;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign dout      = dout_r;

endmodule

// File: rtl/alu1_result_stage.sv
// Alu1 result stage: derives Z/N/C/V at accept time and buffers result, tag and flags
// through a two-entry skid buffer; also tracks illegal commands and retired results.
module alu1_result_stage
    import alu1_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ALU1_CMD_WIDTH-1:0] in_cmd,
    input  logic                      in_a_msb,
    input  logic                      in_b_msb,
    input  logic                      in_co,
    input  logic [WIDTH-1:0]          in_res,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_res,
    output logic [TAG_W-1:0]          out_tag,
    output alu1_flags_t               out_flags,
    output logic                      err_illegal,
    output logic [CNT_W-1:0]          retired_cnt
);

    localparam int DW = WIDTH + TAG_W + 4;

    alu1_flags_t      flags_s;
    logic [DW-1:0]    din_s;
    logic [DW-1:0]    dout_s;
    logic             push_s;
    logic             pop_s;
    logic             illegal_s;
    logic             err_illegal_r;
    logic [CNT_W-1:0] retired_cnt_r;

    assign flags_s   = calc_flags(in_cmd, in_a_msb, in_b_msb, in_res[WIDTH-1],
                                  (in_res == {WIDTH{1'b0}}), in_co);
    assign din_s     = {flags_s, in_tag, in_res};
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;
    assign illegal_s = (in_cmd != CMD_ADD) && (in_cmd != CMD_SUB);

    skid_buf2 #(.DW(DW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout_s)
    );

    // Sticky illegal-command error and wrapping retired-result counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_illegal_r <= 1'b0;
            retired_cnt_r <= '0;
        end else begin
            if (push_s && illegal_s) begin
                err_illegal_r <= 1'b1;
            end
            if (pop_s) begin
                retired_cnt_r <= retired_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign out_res     = dout_s[WIDTH-1:0];
    assign out_tag     = dout_s[WIDTH+TAG_W-1:WIDTH];
    assign out_flags   = dout_s[DW-1:WIDTH+TAG_W];
    assign err_illegal = err_illegal_r;
    assign retired_cnt = retired_cnt_r;

endmodule

// File: tb/tb_alu1_result_stage.sv
// Self-checking bench: an arithmetic Alu1 model feeds the stage; a queue model predicts outputs.
module tb_alu1_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_cmd;
    logic        in_a_msb;
    logic        in_b_msb;
    logic        in_co;
    logic [7:0]  in_res;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_res;
    logic [3:0]  out_tag;
    logic [3:0]  out_flags;
    logic        err_illegal;
    logic [15:0] retired_cnt;

    logic        in_ready4, out_valid4, err_illegal4;
    logic [7:0]  out_res4;
    logic [3:0]  out_tag4, out_flags4, retired_cnt4;

    always #5 clk = ~clk;

    alu1_result_stage #(.WIDTH(8), .TAG_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_cmd(in_cmd), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb), .in_co(in_co),
        .in_res(in_res), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_tag(out_tag), .out_flags(out_flags),
        .err_illegal(err_illegal), .retired_cnt(retired_cnt)
    );

    alu1_result_stage #(.WIDTH(8), .TAG_W(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_cmd(in_cmd), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb), .in_co(in_co),
        .in_res(in_res), .in_tag(in_tag), .out_valid(out_valid4), .out_ready(out_ready),
        .out_res(out_res4), .out_tag(out_tag4), .out_flags(out_flags4),
        .err_illegal(err_illegal4), .retired_cnt(retired_cnt4)
    );

    typedef struct {
        logic [7:0] res;
        logic [3:0] tag;
        logic [3:0] flags;
    } ent_t;

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] tag;
        logic [7:0] exp_res;
        logic [3:0] exp_flags;
    } vec_t;

    ent_t q[$];
    ent_t cur_ent;
    int   m_cnt = 0;
    bit   m_err = 1'b0;
    bit   m_rdy = 1'b1;
    int   pass_cnt = 0;
    int   chk_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Alu1 behaviour and flag rules expressed with plain integer arithmetic.
    task automatic ref_op(input logic [1:0] cmd, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] tag, output logic [7:0] res, output logic co,
                          output ent_t e);
        int sa, sb, r, ua, ub;
        bit v;
        sa = $signed(a); sb = $signed(b);
        ua = int'(a);    ub = int'(b);
        e.tag = tag;
        if (cmd == 2'd0) begin
            r   = sa + sb;
            res = 8'((ua + ub) % 256);
            co  = (ua + ub) > 255;
        end else if (cmd == 2'd1) begin
            r   = sa - sb;
            res = 8'((ua - ub + 256) % 256);
            co  = (ua >= ub);
        end else begin
            r   = 0;
            res = a ^ b;
            co  = 1'($urandom_range(1, 0));
        end
        v = (r > 127) || (r < -128);
        e.res = res;
        if (cmd > 2'd1) e.flags = 4'b0000;
        else e.flags = {v, res[7], co, (res == 8'd0)};
    endtask

    task automatic drive(input logic v, input logic [1:0] cmd, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] tag, input logic ordy);
        logic [7:0] r;
        logic c;
        ent_t e;
        ref_op(cmd, a, b, tag, r, c, e);
        cur_ent   = e;
        in_valid  = v;
        in_cmd    = cmd;
        in_a_msb  = a[7];
        in_b_msb  = b[7];
        in_co     = c;
        in_res    = r;
        in_tag    = tag;
        out_ready = ordy;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 2'd0, 8'd0, 8'd0, 4'd0, ordy);
    endtask

    // One clock: predict push/pop, advance the FIFO model, compare every output.
    task automatic cycle();
        bit push, pop;
        push = in_valid && m_rdy && rst_n;
        pop  = (q.size() > 0) && out_ready && rst_n;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            q.delete();
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            if (pop) begin
                q.delete(0);
                m_cnt++;
            end
            if (push) begin
                q.push_back(cur_ent);
                if (in_cmd > 2'd1) m_err = 1'b1;
            end
        end
        m_rdy = (q.size() < 2);
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(m_rdy));
        chk("err_illegal", 32'(err_illegal), 32'(m_err));
        chk("retired_cnt", 32'(retired_cnt), 32'(m_cnt % 65536));
        chk("retired_cnt4", 32'(retired_cnt4), 32'(m_cnt % 16));
        if (q.size() > 0) begin
            chk("out_res", 32'(out_res), 32'(q[0].res));
            chk("out_tag", 32'(out_tag), 32'(q[0].tag));
            chk("out_flags", 32'(out_flags), 32'(q[0].flags));
        end
    endtask

    initial begin
        vec_t vecs[8];
        vecs[0] = '{2'd0, 8'h40, 8'h40, 4'd1, 8'h80, 4'b1100};
        vecs[1] = '{2'd1, 8'h05, 8'h05, 4'd2, 8'h00, 4'b0011};
        vecs[2] = '{2'd1, 8'h80, 8'h01, 4'd3, 8'h7F, 4'b1010};
        vecs[3] = '{2'd0, 8'hFF, 8'h01, 4'd4, 8'h00, 4'b0011};
        vecs[4] = '{2'd1, 8'h01, 8'h02, 4'd5, 8'hFF, 4'b0100};
        vecs[5] = '{2'd0, 8'h80, 8'h80, 4'd6, 8'h00, 4'b1011};
        vecs[6] = '{2'd2, 8'h00, 8'h00, 4'd7, 8'h00, 4'b0000};
        vecs[7] = '{2'd3, 8'h55, 8'h00, 4'd8, 8'h55, 4'b0000};

        rst_n = 1'b0;
        idle(1'b1);
        cycle();
        cycle();
        chk("rst_out_res", 32'(out_res), 32'h0);
        chk("rst_out_tag", 32'(out_tag), 32'h0);
        chk("rst_out_flags", 32'(out_flags), 32'h0);
        rst_n = 1'b1;

        // Back-to-back stream: 100 ops, one per cycle, then drain.
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 2'($urandom_range(1, 0)), 8'($urandom), 8'($urandom), 4'(i), 1'b1);
            cycle();
            chk("stream_ready", 32'(in_ready), 32'h1);
        end
        idle(1'b1);
        cycle();
        chk("cnt100", 32'(retired_cnt), 32'd100);
        chk("cnt4_100", 32'(retired_cnt4), 32'd4);
        chk("no_illegal", 32'(err_illegal), 32'h0);

        // Flag vectors, each into an empty stage.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].tag, 1'b1);
            cycle();
            chk("vec_valid", 32'(out_valid), 32'h1);
            chk("vec_res", 32'(out_res), 32'(vecs[i].exp_res));
            chk("vec_flags", 32'(out_flags), 32'(vecs[i].exp_flags));
            idle(1'b1);
            cycle();
        end
        chk("err_sticky", 32'(err_illegal), 32'h1);

        // Backpressure: two entries fill the stage, then drain in order.
        drive(1'b1, 2'd0, 8'h01, 8'h02, 4'd1, 1'b0);
        cycle();
        drive(1'b1, 2'd0, 8'h03, 8'h04, 4'd2, 1'b0);
        cycle();
        chk("bp_ready_low", 32'(in_ready), 32'h0);
        chk("bp_tag1", 32'(out_tag), 32'h1);
        drive(1'b1, 2'd0, 8'h05, 8'h06, 4'd3, 1'b0);
        cycle();
        chk("bp_hold_tag1", 32'(out_tag), 32'h1);
        chk("bp_hold_res", 32'(out_res), 32'h03);
        idle(1'b1);
        cycle();
        chk("bp_tag2", 32'(out_tag), 32'h2);
        chk("bp_ready_back", 32'(in_ready), 32'h1);
        cycle();
        chk("bp_empty", 32'(out_valid), 32'h0);

        // Randomized traffic with occasional illegal commands.
        for (int i = 0; i < 400; i++) begin
            logic [1:0] c;
            c = ($urandom_range(7, 0) == 0) ? 2'($urandom_range(3, 2)) : 2'($urandom_range(1, 0));
            drive(1'($urandom_range(3, 0) != 0), c, 8'($urandom), 8'($urandom), 4'($urandom),
                  1'($urandom_range(2, 0) != 0));
            cycle();
        end

        // Reset while two entries are held.
        drive(1'b1, 2'd2, 8'h11, 8'h22, 4'd9, 1'b0);
        cycle();
        drive(1'b1, 2'd1, 8'h33, 8'h44, 4'd10, 1'b0);
        cycle();
        cycle();
        chk("two_before_rst", 32'(in_ready), 32'h0);
        rst_n = 1'b0;
        idle(1'b0);
        cycle();
        rst_n = 1'b1;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h1);
        chk("rst_cnt", 32'(retired_cnt), 32'h0);
        chk("rst_err", 32'(err_illegal), 32'h0);
        idle(1'b1);
        cycle();
        chk("rst_no_output", 32'(out_valid), 32'h0);

        // 17 pops wrap the 4-bit counter to 1.
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 2'd0, 8'($urandom), 8'($urandom), 4'(i), 1'b1);
            cycle();
        end
        idle(1'b1);
        cycle();
        chk("cnt4_wrap", 32'(retired_cnt4), 32'h1);
        chk("cnt17", 32'(retired_cnt), 32'd17);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
